// File: rtl/dsram_responder.sv
// -----------------------------------------------------------------------------
// dsram_responder
//
// A data-SRAM style responder that serves single-cycle requests from a CPU data
// port. The upper halfword of the address splits the space into two regions:
// an MMIO window (LED, SWITCH, TIMER, SCRATCH) and an aliased block RAM of
// 2^ADDR_W 32-bit words. Reads are registered with exactly one cycle of
// latency. Writes are read-first: a request returns the word as it was before
// any write in that same cycle.
//
// Ports
//   clk             : single clock; all state updates on the rising edge
//   resetn          : synchronous, active-low reset
//   data_sram_en    : request valid this cycle
//   data_sram_wen   : byte write enables (4'b0000 = read)
//   data_sram_addr  : byte address ([1:0] ignored)
//   data_sram_wdata : write data
//   data_sram_rdata : registered read data; holds its value when idle
//   switch          : board switch levels (read via MMIO)
//   led             : LED register contents
// -----------------------------------------------------------------------------
module dsram_responder #(
    parameter int          ADDR_W  = 10,
    parameter logic [15:0] MMIO_HI = 16'hBFAF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch,
    output logic [15:0] led
);

    localparam int          DEPTH       = 1 << ADDR_W;
    localparam logic [15:0] OFF_LED     = 16'hF000;
    localparam logic [15:0] OFF_SWITCH  = 16'hF004;
    localparam logic [15:0] OFF_TIMER   = 16'hE000;
    localparam logic [15:0] OFF_SCRATCH = 16'hF010;

    // Request decode
    logic              is_mmio;
    logic [ADDR_W-1:0] word_idx;
    logic [15:0]       mmio_off;
    logic              req_ok;
    logic              is_write;
    logic              ram_wr;
    logic              mmio_wr;
    logic [31:0]       byte_mask;

    assign is_mmio  = (data_sram_addr[31:16] == MMIO_HI);
    assign word_idx = data_sram_addr[ADDR_W+1:2];
    assign mmio_off = {data_sram_addr[15:2], 2'b00};
    // Requests seen during reset are dropped entirely.
    assign req_ok   = resetn & data_sram_en;
    assign is_write = |data_sram_wen;
    assign ram_wr   = req_ok & is_write & ~is_mmio;
    assign mmio_wr  = req_ok & is_write & is_mmio;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_mask
            assign byte_mask[8*gi +: 8] = {8{data_sram_wen[gi]}};
        end
    endgenerate

    // MMIO register state
    logic [15:0] led_q,     led_d;
    logic [31:0] timer_q,   timer_d;
    logic [31:0] scratch_q, scratch_d;

    // Read-path state
    logic [31:0] ram_rd_q;
    logic [31:0] mmio_rd_q;
    logic        sel_mmio_q;
    logic        valid_q;     // cleared by reset so rdata reads 0 until the next request

    logic [31:0] mem [DEPTH];
    logic [31:0] mmio_rdata;

    // MMIO read mux, evaluated against the current (pre-write) register values
    always_comb begin
        mmio_rdata = 32'h0;
        unique case (mmio_off)
            OFF_LED:     mmio_rdata = {16'h0, led_q};
            OFF_SWITCH:  mmio_rdata = {24'h0, switch};
            OFF_TIMER:   mmio_rdata = timer_q;
            OFF_SCRATCH: mmio_rdata = scratch_q;
            default:     mmio_rdata = 32'h0;
        endcase
    end

    // MMIO next-state: byte-lane merges into current values
    always_comb begin
        led_d     = led_q;
        timer_d   = timer_q + 32'd1;
        scratch_d = scratch_q;
        if (mmio_wr) begin
            if (mmio_off == OFF_LED) begin
                // only lanes 0-1 exist in the LED register
                led_d = (led_q & ~byte_mask[15:0]) | (data_sram_wdata[15:0] & byte_mask[15:0]);
            end
            if (mmio_off == OFF_TIMER) begin
                // a write replaces this cycle's increment
                timer_d = (timer_q & ~byte_mask) | (data_sram_wdata & byte_mask);
            end
            if (mmio_off == OFF_SCRATCH) begin
                scratch_d = (scratch_q & ~byte_mask) | (data_sram_wdata & byte_mask);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            led_q      <= 16'h0;
            timer_q    <= 32'h0;
            scratch_q  <= 32'h0;
            mmio_rd_q  <= 32'h0;
            sel_mmio_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            led_q     <= led_d;
            timer_q   <= timer_d;
            scratch_q <= scratch_d;
            if (data_sram_en) begin
                valid_q    <= 1'b1;
                sel_mmio_q <= is_mmio;
                mmio_rd_q  <= mmio_rdata;
            end
        end
    end

    // Block RAM: no reset so contents survive reset; NBA ordering gives read-first.
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wen[i]) begin
                    mem[word_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
        if (req_ok && !is_mmio) begin
            ram_rd_q <= mem[word_idx];
        end
    end

    assign data_sram_rdata = !valid_q   ? 32'h0 :
                             sel_mmio_q ? mmio_rd_q : ram_rd_q;
    assign led             = led_q;

endmodule

// File: tb/tb_dsram_responder.sv
// -----------------------------------------------------------------------------
// tb_dsram_responder
//
// Drives requests on the falling edge, checks outputs 1 time unit after the
// rising edge. A behavioural model (word array, LED/SCRATCH values, and a
// timer expressed as base + elapsed cycles) predicts rdata and led.
// -----------------------------------------------------------------------------
module tb_dsram_responder;

    logic        clk = 1'b0;
    logic        resetn;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic [7:0]  switch;
    logic [15:0] led;

    int checks = 0;
    int errors = 0;
    bit verbose = 1'b0;

    always #5 clk = ~clk;

    dsram_responder #(.ADDR_W(10), .MMIO_HI(16'hBFAF)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .switch          (switch),
        .led             (led)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_mem [1024];
    logic [15:0] m_led;
    logic [31:0] m_scratch;
    logic [31:0] m_timer_base;
    int          m_t0;
    int          cyc;
    logic [31:0] m_rdata;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] timer_now();
        return m_timer_base + 32'(cyc - m_t0);
    endfunction

    // One clock of stimulus; reports the model's prediction and the DUT output.
    task automatic step(input bit rst_n, input bit en, input logic [3:0] wen,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [7:0] sw,
                        output logic [31:0] exp_r, output logic [31:0] got_r,
                        output logic [15:0] exp_l, output logic [15:0] got_l);
        logic [31:0] rd, tnow, tmp;
        int idx;
        @(negedge clk);
        resetn = rst_n; data_sram_en = en; data_sram_wen = wen;
        data_sram_addr = addr; data_sram_wdata = wdata; switch = sw;
        if (!rst_n) begin
            m_rdata = 32'h0; m_led = 16'h0; m_scratch = 32'h0;
            m_timer_base = 32'h0; m_t0 = cyc + 1;
        end else if (en) begin
            tnow = timer_now();
            rd = 32'h0;
            if (addr[31:16] == 16'hBFAF) begin
                case ({addr[15:2], 2'b00})
                    16'hF000: rd = {16'h0, m_led};
                    16'hF004: rd = {24'h0, sw};
                    16'hE000: rd = tnow;
                    16'hF010: rd = m_scratch;
                    default:  rd = 32'h0;
                endcase
                if (wen != 4'h0) begin
                    case ({addr[15:2], 2'b00})
                        16'hF000: begin
                            tmp = merge({16'h0, m_led}, wdata, wen & 4'b0011);
                            m_led = tmp[15:0];
                        end
                        16'hE000: begin
                            m_timer_base = merge(tnow, wdata, wen);
                            m_t0 = cyc + 1;
                        end
                        16'hF010: m_scratch = merge(m_scratch, wdata, wen);
                        default: ;
                    endcase
                end
            end else begin
                idx = int'((addr >> 2) % 1024);
                rd = m_mem[idx];
                if (wen != 4'h0) m_mem[idx] = merge(m_mem[idx], wdata, wen);
            end
            m_rdata = rd;
        end
        cyc++;
        @(posedge clk);
        #1;
        exp_r = m_rdata; got_r = data_sram_rdata;
        exp_l = m_led;   got_l = led;
        if (verbose)
            $display("txn rst_n=%0d en=%0d wen=%h addr=%h wdata=%h -> rdata=%h led=%h",
                     rst_n, en, wen, addr, wdata, got_r, got_l);
    endtask

    logic [31:0] er, gr;
    logic [15:0] el, gl;

    // ---------------- tests ----------------
    task automatic test_reset();
        step(0, 0, 4'h0, 32'h0, 32'h0, 8'h00, er, gr, el, gl);
        step(0, 1, 4'hF, 32'hBFAFF000, 32'hFFFFFFFF, 8'h00, er, gr, el, gl);
        checks++; if (gr !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=%h", gr, 32'h0); end
        checks++; if (gl !== 16'h0) begin errors++; $display("FAIL reset_led got=%h exp=%h", gl, 16'h0); end
        // TIMER reads 0 then 1 right after reset release
        step(1, 1, 4'h0, 32'hBFAFE000, 32'h0, 8'h00, er, gr, el, gl);
        checks++; if (gr !== 32'h0) begin errors++; $display("FAIL timer_first got=%h exp=%h", gr, 32'h0); end
        step(1, 1, 4'h0, 32'hBFAFE000, 32'h0, 8'h00, er, gr, el, gl);
        checks++; if (gr !== 32'h1) begin errors++; $display("FAIL timer_second got=%h exp=%h", gr, 32'h1); end
        step(1, 1, 4'h0, 32'hBFAFF010, 32'h0, 8'h00, er, gr, el, gl);
        checks++; if (gr !== 32'h0) begin errors++; $display("FAIL reset_scratch got=%h exp=%h", gr, 32'h0); end
    endtask

    task automatic test_ram_fill();
        for (int i = 0; i < 1024; i++)
            step(1, 1, 4'hF, 32'(i) << 2, $urandom, 8'h00, er, gr, el, gl);
    endtask

    task automatic test_ram_basic();
        step(1, 1, 4'hF, 32'h10, 32'hDEADBEEF, 8'h00, er, gr, el, gl);
        step(1, 1, 4'h0, 32'h10, 32'h0, 8'h00, er, gr, el, gl);
        checks++; if (gr !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_read got=%h exp=%h", gr, 32'hDEADBEEF); end
        step(1, 1, 4'b0010, 32'h10, 32'h0000AA00, 8'h00, er, gr, el, gl);
        checks++; if (gr !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_read_first got=%h exp=%h", gr, 32'hDEADBEEF); end
        step(1, 1, 4'h0, 32'h10, 32'h0, 8'h00, er, gr, el, gl);
        checks++; if (gr !== 32'hDEADAAEF) begin errors++; $display("FAIL ram_byte_lane got=%h exp=%h", gr, 32'hDEADAAEF); end
        // idle cycles hold rdata
        step(1, 0, 4'hF, 32'h10, 32'h0, 8'h00, er, gr, el, gl);
        checks++; if (gr !== 32'hDEADAAEF) begin errors++; $display("FAIL idle_hold got=%h exp=%h", gr, 32'hDEADAAEF); end
        step(1, 1, 4'h0, 32'h10, 32'h0, 8'h00, er, gr, el, gl);
        checks++; if (gr !== 32'hDEADAAEF) begin errors++; $display("FAIL idle_no_write got=%h exp=%h", gr, 32'hDEADAAEF); end
    endtask

    task automatic test_mmio();
        step(1, 1, 4'hF, 32'hBFAFF000, 32'h12345678, 8'h00, er, gr, el, gl);
        checks++; if (gl !== 16'h5678) begin errors++; $display("FAIL led_write got=%h exp=%h", gl, 16'h5678); end
        step(1, 1, 4'h0, 32'hBFAFF000, 32'h0, 8'h00, er, gr, el, gl);
        checks++; if (gr !== 32'h00005678) begin errors++; $display("FAIL led_read got=%h exp=%h", gr, 32'h00005678); end
        step(1, 1, 4'h0, 32'hBFAFF004, 32'h0, 8'hA5, er, gr, el, gl);
        checks++; if (gr !== 32'h000000A5) begin errors++; $display("FAIL switch_read got=%h exp=%h", gr, 32'h000000A5); end
        // upper LED lanes ignored, lane 1 only
        step(1, 1, 4'b1110, 32'hBFAFF000, 32'hFFFF9900, 8'h00, er, gr, el, gl);
        checks++; if (gl !== 16'h9978) begin errors++; $display("FAIL led_lanes got=%h exp=%h", gl, 16'h9978); end
        step(1, 1, 4'hF, 32'hBFAFF010, 32'hCAFEF00D, 8'h00, er, gr, el, gl);
        step(1, 1, 4'b0101, 32'hBFAFF010, 32'h11223344, 8'h00, er, gr, el, gl);
        checks++; if (gr !== 32'hCAFEF00D) begin errors++; $display("FAIL scratch_read_first got=%h exp=%h", gr, 32'hCAFEF00D); end
        step(1, 1, 4'h0, 32'hBFAFF010, 32'h0, 8'h00, er, gr, el, gl);
        checks++; if (gr !== 32'hCA22F044) begin errors++; $display("FAIL scratch_lanes got=%h exp=%h", gr, 32'hCA22F044); end
    endtask

    task automatic test_timer();
        step(1, 1, 4'hF, 32'hBFAFE000, 32'hFFFFFFFE, 8'h00, er, gr, el, gl);
        for (int i = 0; i < 3; i++) step(1, 0, 4'h0, 32'h0, 32'h0, 8'h00, er, gr, el, gl);
        step(1, 1, 4'h0, 32'hBFAFE000, 32'h0, 8'h00, er, gr, el, gl);
        checks++; if (gr !== 32'h1) begin errors++; $display("FAIL timer_wrap got=%h exp=%h", gr, 32'h1); end
        // whole sequence read cycle by cycle
        step(1, 1, 4'hF, 32'hBFAFE000, 32'hFFFFFFFE, 8'h00, er, gr, el, gl);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] want;
            want = 32'hFFFFFFFE + 32'(i);
            step(1, 1, 4'h0, 32'hBFAFE000, 32'h0, 8'h00, er, gr, el, gl);
            checks++; if (gr !== want) begin errors++; $display("FAIL timer_seq%0d got=%h exp=%h", i, gr, want); end
        end
    endtask

    task automatic test_reset_mid();
        step(0, 1, 4'hF, 32'hBFAFF010, 32'h1, 8'h00, er, gr, el, gl);
        checks++; if (gr !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h exp=%h", gr, 32'h0); end
        checks++; if (gl !== 16'h0) begin errors++; $display("FAIL rst_led got=%h exp=%h", gl, 16'h0); end
        step(1, 1, 4'h0, 32'hBFAFF010, 32'h0, 8'h00, er, gr, el, gl);
        checks++; if (gr !== 32'h0) begin errors++; $display("FAIL rst_scratch got=%h exp=%h", gr, 32'h0); end
        step(1, 1, 4'h0, 32'h10, 32'h0, 8'h00, er, gr, el, gl);
        checks++; if (gr !== 32'hDEADAAEF) begin errors++; $display("FAIL ram_retained got=%h exp=%h", gr, 32'hDEADAAEF); end
    endtask

    task automatic test_unmapped_alias();
        step(1, 1, 4'hF, 32'hBFAF0100, 32'hFFFFFFFF, 8'h00, er, gr, el, gl);
        step(1, 1, 4'h0, 32'hBFAF0100, 32'h0, 8'h00, er, gr, el, gl);
        checks++; if (gr !== 32'h0) begin errors++; $display("FAIL unmapped got=%h exp=%h", gr, 32'h0); end
        step(1, 1, 4'h0, 32'h00001010, 32'h0, 8'h00, er, gr, el, gl);
        checks++; if (gr !== 32'hDEADAAEF) begin errors++; $display("FAIL alias got=%h exp=%h", gr, 32'hDEADAAEF); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            logic [31:0] a, d;
            a = {$urandom_range(0, 16'hBFAE), 16'(($urandom & 16'h0FFF) << 2)};
            d = $urandom;
            step(1, 1, 4'hF, a, d, 8'h00, er, gr, el, gl);
            step(1, 1, 4'h0, a, 32'h0, 8'h00, er, gr, el, gl);
            checks++; if (gr !== d) begin errors++; $display("FAIL b2b_%0d got=%h exp=%h", i, gr, d); end
        end
    endtask

    task automatic test_random();
        logic [15:0] offs [6];
        offs = '{16'hF000, 16'hF004, 16'hE000, 16'hF010, 16'h0100, 16'hF008};
        verbose = 1'b1;
        for (int i = 0; i < 400; i++) begin
            bit rn, en;
            logic [3:0] wen;
            logic [31:0] a;
            rn  = ($urandom_range(0, 49) != 0);
            en  = ($urandom_range(0, 3) != 0);
            wen = ($urandom_range(0, 1) != 0) ? 4'(($urandom)) : 4'h0;
            if ($urandom_range(0, 2) == 0)
                a = {16'hBFAF, offs[$urandom_range(0, 5)] | 16'($urandom_range(0, 3))};
            else
                a = $urandom;
            step(rn, en, wen, a, $urandom, 8'($urandom), er, gr, el, gl);
            checks++; if (gr !== er) begin errors++; $display("FAIL rand_rdata_%0d got=%h exp=%h", i, gr, er); end
            checks++; if (gl !== el) begin errors++; $display("FAIL rand_led_%0d got=%h exp=%h", i, gl, el); end
        end
        verbose = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; data_sram_en = 1'b0; data_sram_wen = 4'h0;
        data_sram_addr = 32'h0; data_sram_wdata = 32'h0; switch = 8'h00;
        cyc = 0; m_t0 = 0; m_timer_base = 32'h0; m_rdata = 32'h0;
        m_led = 16'h0; m_scratch = 32'h0;
        for (int i = 0; i < 1024; i++) m_mem[i] = 32'h0;
        test_reset();
        test_ram_fill();
        test_ram_basic();
        test_mmio();
        test_timer();
        test_reset_mid();
        test_unmapped_alias();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
